// File: rtl/pipe_hazard_ctrl.sv
// Hazard/freeze/redirect sequencer for the PC, IF/ID and ID/EX registers of the 5-stage pipe.
// Optional macro PIPE_STALL_CNT_EN adds a saturating 32-bit stall counter output (stall_cnt).
module pipe_hazard_ctrl #(
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             br_taken,
    input  logic             mc_start,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
`ifdef PIPE_STALL_CNT_EN
    output logic [31:0]      stall_cnt,
`endif
    output logic             busy
);

    typedef enum logic {RUN, MC_STALL} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             live_q, live_d;
    logic             load_use;

    // Register 0 is hardwired zero, so a load targeting it can never create a dependency.
    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        live_d      = 1'b1;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_write  = 1'b0;
        idex_bubble = 1'b0;
        busy        = 1'b0;
        if (live_q) begin
            case (state_q)
                RUN: begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    idex_write = 1'b1;
                    if (br_taken) begin
                        pc_src      = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (mc_start) begin
                        // The mc_start cycle is the first of MC_LAT frozen cycles.
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_write = 1'b0;
                        state_d    = MC_STALL;
                        cnt_d      = CNT_W'(MC_LAT - 2);
                    end else if (load_use) begin
                        // idex_write stays high so the bubble NOP is actually written.
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                MC_STALL: begin
                    busy = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= live_d;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (live_q && !pc_write) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver queues expected outputs, negedge monitor checks them.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       ex_mem_read = 1'b0, br_taken = 1'b0, mc_start = 1'b0;
    logic       pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_bubble, busy;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [6:0] exp;
        string      name;
    } sb_item_t;

    sb_item_t sb[$];

    // Expected vectors: {pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_bubble, busy}
    localparam logic [6:0] E_OFF  = 7'b0000000;
    localparam logic [6:0] E_RUN  = 7'b1010100;
    localparam logic [6:0] E_LU   = 7'b0000110;
    localparam logic [6:0] E_MC0  = 7'b0000000;
    localparam logic [6:0] E_BUSY = 7'b0000001;
    localparam logic [6:0] E_BR   = 7'b1111110;

    pipe_hazard_ctrl #(.MC_LAT(4), .CNT_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .br_taken    (br_taken),
        .mc_start    (mc_start),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .ifid_write  (ifid_write),
        .ifid_flush  (ifid_flush),
        .idex_write  (idex_write),
        .idex_bubble (idex_bubble),
`ifdef PIPE_STALL_CNT_EN
        .stall_cnt   (stall_cnt),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic mr, input logic [4:0] xrt, input logic br,
                        input logic mc, input logic [6:0] exp, input string name);
        sb_item_t it;
        @(posedge clk);
        #1;
        rst = r; id_rs = rs; id_rt = rt; ex_mem_read = mr; ex_rt = xrt;
        br_taken = br; mc_start = mc;
        it.exp = exp;
        it.name = name;
        sb.push_back(it);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_item_t it;
            logic [6:0] act;
            it  = sb.pop_front();
            act = {pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_bubble, busy};
            total++;
            if (act !== it.exp) begin
                bad++;
                $display("FAIL %s: got %b expected %b", it.name, act, it.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held 3 cycles, then one dead cycle before live
        step(0, 0, 0, 0, 0, 0, 0, E_OFF, "rst_c1");
        step(0, 0, 0, 1, 5, 1, 1, E_OFF, "rst_c2");
        step(0, 5, 0, 1, 5, 0, 1, E_OFF, "rst_c3");
        step(1, 0, 0, 0, 0, 0, 1, E_OFF, "first_live0");
        step(1, 0, 0, 0, 0, 0, 0, E_RUN, "run_default");

        // load-use
        step(1, 5, 0, 1, 5, 0, 0, E_LU,  "lu_rs");
        step(1, 5, 0, 0, 5, 0, 0, E_RUN, "lu_clear");
        step(1, 3, 7, 1, 7, 0, 0, E_LU,  "lu_rt");
        step(1, 0, 0, 1, 0, 0, 0, E_RUN, "lu_r0");
        step(1, 6, 4, 1, 5, 0, 0, E_RUN, "lu_nomatch");
        step(1, 9, 9, 1, 9, 0, 0, E_LU,  "lu_hold1");
        step(1, 9, 9, 1, 9, 0, 0, E_LU,  "lu_hold2");
        step(1, 0, 0, 0, 0, 0, 0, E_RUN, "lu_done");

        // multi-cycle freeze, branch in cycle 3 ignored
        step(1, 0, 0, 0, 0, 0, 1, E_MC0,  "mc_c1");
        step(1, 5, 0, 1, 5, 0, 1, E_BUSY, "mc_c2");
        step(1, 0, 0, 0, 0, 1, 0, E_BUSY, "mc_c3_br");
        step(1, 0, 0, 0, 0, 0, 0, E_BUSY, "mc_c4");
        step(1, 0, 0, 0, 0, 0, 0, E_RUN,  "mc_after");

        // branch beats mc_start and load-use
        step(1, 5, 0, 1, 5, 1, 1, E_BR,  "br_prio");
        step(1, 0, 0, 0, 0, 0, 0, E_RUN, "br_after");
        step(1, 0, 0, 0, 0, 1, 0, E_BR,  "br_plain");

        // reset in the second MC_STALL cycle
        step(1, 0, 0, 0, 0, 0, 1, E_MC0,  "rmf_c1");
        step(1, 0, 0, 0, 0, 0, 0, E_BUSY, "rmf_stall1");
        step(0, 0, 0, 0, 0, 0, 0, E_OFF,  "rmf_abort");
        step(0, 0, 0, 0, 0, 0, 0, E_OFF,  "rmf_held");
        step(1, 0, 0, 0, 0, 0, 0, E_OFF,  "rmf_live0");
        step(1, 0, 0, 0, 0, 0, 0, E_RUN,  "rmf_run");
        step(1, 0, 0, 0, 0, 0, 1, E_MC0,  "rmf2_c1");
        step(1, 0, 0, 0, 0, 0, 0, E_BUSY, "rmf2_c2");
        step(1, 0, 0, 0, 0, 0, 0, E_BUSY, "rmf2_c3");
        step(1, 0, 0, 0, 0, 0, 0, E_BUSY, "rmf2_c4");
        step(1, 0, 0, 0, 0, 0, 0, E_RUN,  "rmf2_after");
        step(1, 2, 0, 1, 2, 0, 0, E_LU,   "cnt_lu");
        step(1, 0, 0, 0, 0, 0, 0, E_RUN,  "cnt_run");
`ifdef PIPE_STALL_CNT_EN
        total++;
        if (stall_cnt !== 32'd5) begin
            bad++;
            $display("FAIL stall_cnt: got %0d expected 5", stall_cnt);
        end
`endif
        step(1, 0, 0, 0, 0, 0, 0, E_RUN, "tail");

        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
